matrix_stream_tx: RTL and testbench

- Transmit side of the packed matrix bus: takes one packed result matrix (for example, the sum produced by the adder unit) plus its dimensions, and emits the active elements one at a time in row-major order.
- Uses a valid/ready handshake with row-end and last markers.
- Sits between the matrix arithmetic units and the serial/display output path. Lets downstream logic consume results element by element instead of as a 200-bit word.

---
 rtl/matrix_stream_tx.sv | 129 ++++++++++++
 tb/tb_matrix_stream_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_stream_tx.sv
// Serialises a packed MAX_DIM x MAX_DIM matrix into a row-major element stream
// using a valid/ready handshake with row-end and last markers.
module matrix_stream_tx #(
    parameter int unsigned ELEM_W  = 8,
    parameter int unsigned MAX_DIM = 5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [2:0]                        m,
    input  logic [2:0]                        n,
    input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] matrix_in,
    input  logic                              out_ready,
    output logic [ELEM_W-1:0]                 elem_data,
    output logic                              elem_valid,
    output logic [2:0]                        elem_row,
    output logic [2:0]                        elem_col,
    output logic                              row_end,
    output logic                              last,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);

    localparam int unsigned NUM_ELEM = MAX_DIM * MAX_DIM;
    localparam int unsigned MAT_W    = NUM_ELEM * ELEM_W;
    localparam int unsigned DIM_W    = 3;
    localparam int unsigned IDX_W    = $clog2(NUM_ELEM) + 1;

    typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

    state_t             state;
    logic [MAT_W-1:0]   mat_q;
    logic [DIM_W-1:0]   m_q;
    logic [DIM_W-1:0]   n_q;
    logic [ELEM_W-1:0]  elems [NUM_ELEM];

    logic               dims_ok_c;
    logic               xfer_c;
    logic [DIM_W-1:0]   next_row_c;
    logic [DIM_W-1:0]   next_col_c;
    logic [IDX_W-1:0]   next_idx_c;

    // Flat view of the latched matrix, indexed by i*MAX_DIM+j
    for (genvar g = 0; g < NUM_ELEM; g++) begin : g_unpack
        assign elems[g] = mat_q[g*ELEM_W +: ELEM_W];
    end

    // Dimension check and the position of the element after the current one
    always_comb begin
        dims_ok_c  = (m != '0) && (n != '0) &&
                     (32'(m) <= MAX_DIM) && (32'(n) <= MAX_DIM);
        xfer_c     = elem_valid && out_ready;
        next_row_c = elem_row;
        next_col_c = elem_col + DIM_W'(1);
        if (elem_col == n_q - DIM_W'(1)) begin
            next_row_c = elem_row + DIM_W'(1);
            next_col_c = '0;
        end
        next_idx_c = IDX_W'(32'(next_row_c) * MAX_DIM + 32'(next_col_c));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            mat_q      <= '0;
            m_q        <= '0;
            n_q        <= '0;
            elem_data  <= '0;
            elem_valid <= 1'b0;
            elem_row   <= '0;
            elem_col   <= '0;
            row_end    <= 1'b0;
            last       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (dims_ok_c) begin
                            mat_q      <= matrix_in;
                            m_q        <= m;
                            n_q        <= n;
                            elem_row   <= '0;
                            elem_col   <= '0;
                            elem_data  <= matrix_in[ELEM_W-1:0];
                            elem_valid <= 1'b1;
                            busy       <= 1'b1;
                            row_end    <= (n == DIM_W'(1));
                            last       <= (m == DIM_W'(1)) && (n == DIM_W'(1));
                            state      <= SEND;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (xfer_c) begin
                        if (last) begin
                            elem_data  <= '0;
                            elem_valid <= 1'b0;
                            elem_row   <= '0;
                            elem_col   <= '0;
                            row_end    <= 1'b0;
                            last       <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state      <= FIN;
                        end else begin
                            elem_row  <= next_row_c;
                            elem_col  <= next_col_c;
                            elem_data <= elems[next_idx_c];
                            row_end   <= (next_col_c == n_q - DIM_W'(1));
                            last      <= (next_row_c == m_q - DIM_W'(1)) &&
                                         (next_col_c == n_q - DIM_W'(1));
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_stream_tx.sv
// Directed bench for matrix_stream_tx: table of stream cases plus
// hand-written reset-abort and reset-state sequences.
module tb_matrix_stream_tx;

    localparam int unsigned ELEM_W  = 8;
    localparam int unsigned MAX_DIM = 5;
    localparam int unsigned MAT_W   = MAX_DIM * MAX_DIM * ELEM_W;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [2:0]         m;
    logic [2:0]         n;
    logic [MAT_W-1:0]   matrix_in;
    logic               out_ready;
    logic [ELEM_W-1:0]  elem_data;
    logic               elem_valid;
    logic [2:0]         elem_row;
    logic [2:0]         elem_col;
    logic               row_end;
    logic               last;
    logic               busy;
    logic               done;
    logic               err;

    matrix_stream_tx #(.ELEM_W(ELEM_W), .MAX_DIM(MAX_DIM)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .m          (m),
        .n          (n),
        .matrix_in  (matrix_in),
        .out_ready  (out_ready),
        .elem_data  (elem_data),
        .elem_valid (elem_valid),
        .elem_row   (elem_row),
        .elem_col   (elem_col),
        .row_end    (row_end),
        .last       (last),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // fill: 0 -> 10*i+j, 1 -> 1..25 row-major, 2 -> FF, 3 -> 16*i+j+0x30
    // rmode: 0 -> ready always 1, 1 -> ready 1,0,1,0...
    // poke: cycle at which start is re-pulsed mid-stream with new matrix/dims
    typedef struct {
        int m;
        int n;
        int fill;
        int rmode;
        int poke;
        bit exp_err;
    } case_t;

    case_t cases [7];
    int    checks = 0;
    int    errors = 0;
    int    cur    = -1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL case%0d %s: got %0d expected %0d", cur, name, act, exp);
        end
    endtask

    function automatic logic [7:0] elem_val(input int fill, input int i, input int j);
        case (fill)
            0:       return 8'(10 * i + j);
            1:       return 8'(i * 5 + j + 1);
            2:       return 8'hFF;
            default: return 8'(16 * i + j + 48);
        endcase
    endfunction

    // Positions outside m x n get distinct junk so a bad index shows up
    function automatic logic [MAT_W-1:0] build(input int mm, input int nn, input int fill);
        logic [MAT_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(MAX_DIM); i++)
            for (int j = 0; j < int'(MAX_DIM); j++)
                if (i < mm && j < nn)
                    r[(i*MAX_DIM+j)*ELEM_W +: ELEM_W] = elem_val(fill, i, j);
                else
                    r[(i*MAX_DIM+j)*ELEM_W +: ELEM_W] = 8'(8'hA5 ^ (i * 5 + j));
        return r;
    endfunction

    task automatic run_case(input case_t c);
        logic [MAT_W-1:0] mat;
        int total, k, cyc, i, j;
        mat = build(c.m, c.n, c.fill);
        @(negedge clk);
        start     = 1'b1;
        m         = 3'(c.m);
        n         = 3'(c.n);
        matrix_in = mat;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        if (c.exp_err) begin
            check("err_pulse", int'(err), 1);
            check("err_valid", int'(elem_valid), 0);
            check("err_busy", int'(busy), 0);
            @(negedge clk);
            check("err_clear", int'(err), 0);
            check("err_valid2", int'(elem_valid), 0);
            check("err_busy2", int'(busy), 0);
            return;
        end
        check("no_err", int'(err), 0);
        total = c.m * c.n;
        k     = 0;
        cyc   = 0;
        while (k < total && cyc < 200) begin
            check("valid", int'(elem_valid), 1);
            check("busy", int'(busy), 1);
            check("done_low", int'(done), 0);
            if (elem_valid) begin
                i = k / c.n;
                j = k % c.n;
                check("data", int'(elem_data), int'(elem_val(c.fill, i, j)));
                check("row", int'(elem_row), i);
                check("col", int'(elem_col), j);
                check("row_end", int'(row_end), int'(j == c.n - 1));
                check("last", int'(last), int'(k == total - 1));
            end
            if (c.poke != 0 && cyc == c.poke) begin
                start     = 1'b1;
                m         = 3'd4;
                n         = 3'd4;
                matrix_in = ~mat;
            end else begin
                start = 1'b0;
            end
            out_ready = (c.rmode == 0) ? 1'b1 : 1'((cyc % 2) == 0);
            if (elem_valid && out_ready) k++;
            cyc++;
            @(negedge clk);
        end
        start     = 1'b0;
        out_ready = 1'b0;
        check("transfer_count", k, total);
        check("done_pulse", int'(done), 1);
        check("fin_busy", int'(busy), 0);
        check("fin_valid", int'(elem_valid), 0);
        if (c.poke != 0) begin
            start = 1'b1;
            m     = 3'd2;
            n     = 3'd2;
        end
        @(negedge clk);
        start = 1'b0;
        check("done_clear", int'(done), 0);
        check("idle_valid", int'(elem_valid), 0);
        check("idle_busy", int'(busy), 0);
        @(negedge clk);
        check("idle_valid2", int'(elem_valid), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, int'(elem_data), 0);
        check({tag, "_valid"}, int'(elem_valid), 0);
        check({tag, "_row"}, int'(elem_row), 0);
        check({tag, "_col"}, int'(elem_col), 0);
        check({tag, "_row_end"}, int'(row_end), 0);
        check({tag, "_last"}, int'(last), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_err"}, int'(err), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MAT_W-1:0] mat3;
        case_t            tail;

        cases[0] = '{m: 2, n: 3, fill: 0, rmode: 0, poke: 0, exp_err: 1'b0};
        cases[1] = '{m: 5, n: 5, fill: 1, rmode: 1, poke: 0, exp_err: 1'b0};
        cases[2] = '{m: 0, n: 3, fill: 0, rmode: 0, poke: 0, exp_err: 1'b1};
        cases[3] = '{m: 6, n: 2, fill: 0, rmode: 0, poke: 0, exp_err: 1'b1};
        cases[4] = '{m: 1, n: 1, fill: 2, rmode: 0, poke: 0, exp_err: 1'b0};
        cases[5] = '{m: 2, n: 3, fill: 0, rmode: 0, poke: 2, exp_err: 1'b0};
        cases[6] = '{m: 3, n: 4, fill: 3, rmode: 1, poke: 0, exp_err: 1'b0};

        reset     = 1'b0;
        start     = 1'b1;
        m         = 3'd2;
        n         = 3'd2;
        matrix_in = '1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        for (int t = 0; t < 7; t++) begin
            cur = t;
            run_case(cases[t]);
        end

        // Reset after the third transfer of a 3x3 stream abandons it
        cur  = 7;
        mat3 = build(3, 3, 3);
        @(negedge clk);
        start     = 1'b1;
        m         = 3'd3;
        n         = 3'd3;
        matrix_in = mat3;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_row", int'(elem_row), 1);
        check("abort_col", int'(elem_col), 0);
        check("abort_data", int'(elem_data), int'(elem_val(3, 1, 0)));
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        reset = 1'b1;
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            check("abort_no_done", int'(done), 0);
            check("abort_idle_valid", int'(elem_valid), 0);
        end

        cur  = 8;
        tail = '{m: 1, n: 2, fill: 0, rmode: 0, poke: 0, exp_err: 1'b0};
        run_case(tail);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
